// File: rtl/m_wb_arb_if.sv
// Write-back arbiter bus: pipeline write-back, long-latency issue/result, register-file port.
// Latency: none; this file only bundles wires.
// Backpressure: w_l_ready throttles long-latency results; w_p_stall holds the pipeline (anti-starve build).
interface m_wb_arb_if #(
    parameter int AW = 2
);
    logic        w_p_we;
    logic [4:0]  w_p_wa;
    logic [31:0] w_p_wd;
    logic        w_p_stall;
    logic        w_iss;
    logic [4:0]  w_iss_rd;
    logic        w_l_valid;
    logic        w_l_ready;
    logic [4:0]  w_l_wa;
    logic [31:0] w_l_wd;
    logic        w_rf_we;
    logic [4:0]  w_rf_wa;
    logic [31:0] w_rf_wd;
    logic [31:0] w_busy;
    logic [AW:0] w_cnt;

    // Driver side: pipeline, issue logic and long-latency units.
    modport master (
        output w_p_we, w_p_wa, w_p_wd, w_iss, w_iss_rd, w_l_valid, w_l_wa, w_l_wd,
        input  w_p_stall, w_l_ready, w_rf_we, w_rf_wa, w_rf_wd, w_busy, w_cnt
    );

    // Arbiter side.
    modport slave (
        input  w_p_we, w_p_wa, w_p_wd, w_iss, w_iss_rd, w_l_valid, w_l_wa, w_l_wd,
        output w_p_stall, w_l_ready, w_rf_we, w_rf_wa, w_rf_wd, w_busy, w_cnt
    );
endinterface

// File: rtl/m_wb_arb.sv
// Write-back arbiter: pipeline write-back has priority, long-latency results queue in a FIFO; busy scoreboard.
// Latency: pipeline write 1 cycle to w_rf_*, FIFO result 2 cycles minimum from acceptance.
// Backpressure: w_l_ready = FIFO not full; optional WB_ANTI_STARVE_EN forces a drain and raises w_p_stall.
module m_wb_arb #(
    parameter int DEPTH  = 4,
    parameter int AW     = 2,
    parameter int STARVE = 4
) (
    input  logic     w_clk,
    input  logic     w_rst,
    m_wb_arb_if.slave wb
);
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [4:0]    mem_wa_q [DEPTH];
    logic [31:0]   mem_wd_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   cnt_q, cnt_d;
    logic [31:0]   busy_q, busy_d;
    logic          rf_we_q, rf_we_d;
    logic [4:0]    rf_wa_q, rf_wa_d;
    logic [31:0]   rf_wd_q, rf_wd_d;

    logic       l_ready;
    logic       push;
    logic       pop;
    logic       p_req;
    logic       p_win;
    logic       force_pop;
    logic [4:0] head_wa;
    logic [31:0] head_wd;

    assign l_ready = (cnt_q != CNT_FULL);
    // Writes to x0 complete the handshake but never occupy a slot.
    assign push    = wb.w_l_valid & l_ready & (wb.w_l_wa != 5'd0);
    assign p_req   = wb.w_p_we & (wb.w_p_wa != 5'd0);
    assign p_win   = p_req & ~force_pop;
    assign pop     = (cnt_q != '0) & (~p_req | force_pop);
    assign head_wa = mem_wa_q[rd_ptr_q];
    assign head_wd = mem_wd_q[rd_ptr_q];

`ifdef WB_ANTI_STARVE_EN
    // Counter is sized one step past STARVE so STARVE=0 still yields a legal width.
    localparam int SW = $clog2(STARVE + 2);
    logic [SW-1:0] starve_q, starve_d;

    assign force_pop    = (starve_q == SW'(STARVE));
    assign wb.w_p_stall = force_pop;

    // Count cycles the queue head is blocked by the pipeline; any drain or empty queue restarts it.
    always_comb begin
        starve_d = starve_q;
        if ((cnt_q == '0) || pop) begin
            starve_d = '0;
        end else if (p_win) begin
            starve_d = starve_q + SW'(1);
        end
    end

    // Starve counter register.
    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    // Strict pipeline priority; STARVE only matters when the counter is built.
    logic unused_starve;
    assign unused_starve = (STARVE != 0);
    assign force_pop     = 1'b0;
    assign wb.w_p_stall  = 1'b0;
`endif

    // Occupancy, scoreboard and register-file port next state.
    always_comb begin
        cnt_d = cnt_q;
        if (push && !pop) begin
            cnt_d = cnt_q + CNT_ONE;
        end else if (!push && pop) begin
            cnt_d = cnt_q - CNT_ONE;
        end

        // Clear before set so a same-cycle re-issue keeps the register busy.
        busy_d = busy_q;
        if (pop) begin
            busy_d[head_wa] = 1'b0;
        end
        if (wb.w_iss && (wb.w_iss_rd != 5'd0)) begin
            busy_d[wb.w_iss_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;

        // Address/data hold their last value on idle cycles.
        rf_we_d = 1'b0;
        rf_wa_d = rf_wa_q;
        rf_wd_d = rf_wd_q;
        if (p_win) begin
            rf_we_d = 1'b1;
            rf_wa_d = wb.w_p_wa;
            rf_wd_d = wb.w_p_wd;
        end else if (pop) begin
            rf_we_d = 1'b1;
            rf_wa_d = head_wa;
            rf_wd_d = head_wd;
        end
    end

    // FIFO storage; contents are don't-care until the pointers say otherwise, so no reset.
    always_ff @(posedge w_clk) begin
        if (push) begin
            mem_wa_q[wr_ptr_q] <= wb.w_l_wa;
            mem_wd_q[wr_ptr_q] <= wb.w_l_wd;
        end
    end

    // Control state: pointers, count, scoreboard and the registered write port.
    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            busy_q   <= '0;
            rf_we_q  <= 1'b0;
            rf_wa_q  <= '0;
            rf_wd_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            rf_we_q <= rf_we_d;
            rf_wa_q <= rf_wa_d;
            rf_wd_q <= rf_wd_d;
        end
    end

    assign wb.w_l_ready = l_ready;
    assign wb.w_rf_we   = rf_we_q;
    assign wb.w_rf_wa   = rf_wa_q;
    assign wb.w_rf_wd   = rf_wd_q;
    assign wb.w_busy    = busy_q;
    assign wb.w_cnt     = cnt_q;
endmodule

// File: tb/tb_m_wb_arb.sv
// Testbench for m_wb_arb: directed scenarios plus randomized traffic against a queue-based model.
// Latency: model advances one clock per tick; outputs sampled 1 ns after the rising edge.
// Backpressure: random driver respects w_l_ready via the model and holds the pipeline while stalled.
`timescale 1ns/1ps
module tb_m_wb_arb;
    localparam int DEPTH  = 4;
    localparam int AW     = 2;
    localparam int STARVE = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    m_wb_arb_if #(.AW(AW)) bus ();

    m_wb_arb #(.DEPTH(DEPTH), .AW(AW), .STARVE(STARVE)) dut (
        .w_clk (clk),
        .w_rst (rst),
        .wb    (bus)
    );

    // Reference model: queue of accepted results, busy set, last register-file write.
    logic [36:0] m_q [$];
    logic [31:0] m_busy   = '0;
    logic        m_we     = 1'b0;
    logic [4:0]  m_wa     = '0;
    logic [31:0] m_wd     = '0;
    int          m_starve = 0;

    // Apply one clock: compute what the edge should do from current inputs, then advance.
    task automatic tick();
        logic [36:0] e;
        bit pw, frc, popped, rdy;
        int sz;
        sz     = m_q.size();
        rdy    = (sz != DEPTH);
        pw     = bus.w_p_we && (bus.w_p_wa != 5'd0);
        frc    = 1'b0;
        popped = 1'b0;
`ifdef WB_ANTI_STARVE_EN
        frc = (m_starve == STARVE);
`endif
        if (rst) begin
            m_q.delete();
            m_busy = '0; m_we = 1'b0; m_wa = '0; m_wd = '0; m_starve = 0;
        end else begin
            if (pw && !frc) begin
                m_we = 1'b1; m_wa = bus.w_p_wa; m_wd = bus.w_p_wd;
            end else if (sz != 0) begin
                e = m_q.pop_front();
                popped = 1'b1;
                m_we = 1'b1; m_wa = e[36:32]; m_wd = e[31:0];
                m_busy[e[36:32]] = 1'b0;
            end else begin
                m_we = 1'b0;
            end
            if (bus.w_iss && bus.w_iss_rd != 5'd0) m_busy[bus.w_iss_rd] = 1'b1;
            if (bus.w_l_valid && rdy && bus.w_l_wa != 5'd0) m_q.push_back({bus.w_l_wa, bus.w_l_wd});
            if (sz == 0 || popped) m_starve = 0;
            else if (pw) m_starve = m_starve + 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.w_p_we = 0; bus.w_p_wa = 0; bus.w_p_wd = 0;
        bus.w_iss = 0; bus.w_iss_rd = 0;
        bus.w_l_valid = 0; bus.w_l_wa = 0; bus.w_l_wd = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1; tick(); rst = 0;
        tick(); tick(); tick();
        checks++; if (bus.w_rf_we !== 1'b0) begin errors++; $display("FAIL reset_we got %b want 0", bus.w_rf_we); end
        checks++; if (bus.w_busy !== 32'd0) begin errors++; $display("FAIL reset_busy got %h want 0", bus.w_busy); end
        checks++; if (bus.w_cnt !== 3'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", bus.w_cnt); end
        checks++; if (bus.w_l_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", bus.w_l_ready); end
        checks++; if (bus.w_p_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", bus.w_p_stall); end
    endtask

    task automatic test_pipe_write();
        bus.w_p_we = 1; bus.w_p_wa = 5; bus.w_p_wd = 32'h12345678;
        tick();
        bus.w_p_we = 0;
        checks++; if ({bus.w_rf_we, bus.w_rf_wa, bus.w_rf_wd} !== {1'b1, 5'd5, 32'h12345678}) begin
            errors++; $display("FAIL pipe_write got we=%b wa=%0d wd=%h want 1/5/12345678", bus.w_rf_we, bus.w_rf_wa, bus.w_rf_wd); end
        tick();
        checks++; if ({bus.w_rf_we, bus.w_rf_wa} !== {1'b0, 5'd5}) begin
            errors++; $display("FAIL pipe_one_shot got we=%b wa=%0d want 0/5", bus.w_rf_we, bus.w_rf_wa); end
        bus.w_p_we = 1; bus.w_p_wa = 0; bus.w_p_wd = 32'hDEADBEEF;
        tick();
        bus.w_p_we = 0;
        checks++; if (bus.w_rf_we !== 1'b0) begin errors++; $display("FAIL pipe_x0_dropped got we=%b want 0", bus.w_rf_we); end
        tick();
    endtask

    task automatic test_long_latency();
        bus.w_iss = 1; bus.w_iss_rd = 7;
        tick();
        bus.w_iss = 0;
        checks++; if (bus.w_busy[7] !== 1'b1) begin errors++; $display("FAIL issue_busy got %b want 1", bus.w_busy[7]); end
        bus.w_l_valid = 1; bus.w_l_wa = 7; bus.w_l_wd = 32'hA5A5A5A5;
        tick();
        bus.w_l_valid = 0;
        checks++; if ({bus.w_rf_we, bus.w_cnt} !== {1'b0, 3'd1}) begin
            errors++; $display("FAIL ll_accept got we=%b cnt=%0d want 0/1", bus.w_rf_we, bus.w_cnt); end
        tick();
        checks++; if ({bus.w_rf_we, bus.w_rf_wa, bus.w_rf_wd} !== {1'b1, 5'd7, 32'hA5A5A5A5}) begin
            errors++; $display("FAIL ll_write got we=%b wa=%0d wd=%h want 1/7/a5a5a5a5", bus.w_rf_we, bus.w_rf_wa, bus.w_rf_wd); end
        checks++; if ({bus.w_busy[7], bus.w_cnt} !== {1'b0, 3'd0}) begin
            errors++; $display("FAIL ll_clear got busy7=%b cnt=%0d want 0/0", bus.w_busy[7], bus.w_cnt); end
        tick();
    endtask

    task automatic test_fill_order();
        bus.w_p_we = 1; bus.w_p_wa = 20; bus.w_p_wd = 32'h2020;
        for (int k = 1; k <= 4; k++) begin
            bus.w_l_valid = 1; bus.w_l_wa = 5'(k); bus.w_l_wd = 32'h100 + k;
            tick();
        end
        bus.w_l_wa = 5; bus.w_l_wd = 32'h105;
        checks++; if ({bus.w_l_ready, bus.w_cnt} !== {1'b0, 3'd4}) begin
            errors++; $display("FAIL fill_full got ready=%b cnt=%0d want 0/4", bus.w_l_ready, bus.w_cnt); end
        tick(); tick();
        checks++; if ({bus.w_cnt, bus.w_rf_wa} !== {3'd4, 5'd20}) begin
            errors++; $display("FAIL fill_blocked got cnt=%0d wa=%0d want 4/20", bus.w_cnt, bus.w_rf_wa); end
        bus.w_p_we = 0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (k == 2) bus.w_l_valid = 0;
            checks++; if ({bus.w_rf_we, bus.w_rf_wa, bus.w_rf_wd} !== {1'b1, 5'(k), 32'h100 + k}) begin
                errors++; $display("FAIL drain_order[%0d] got we=%b wa=%0d wd=%h want 1/%0d/%h", k, bus.w_rf_we, bus.w_rf_wa, bus.w_rf_wd, k, 32'h100 + k); end
        end
        checks++; if (bus.w_cnt !== 3'd0) begin errors++; $display("FAIL drain_empty got cnt=%0d want 0", bus.w_cnt); end
        tick();
    endtask

    task automatic test_same_cycle_set();
        bus.w_iss = 1; bus.w_iss_rd = 9;
        tick();
        bus.w_iss = 0;
        bus.w_l_valid = 1; bus.w_l_wa = 9; bus.w_l_wd = 32'h99;
        tick();
        bus.w_l_valid = 0;
        bus.w_iss = 1; bus.w_iss_rd = 9;
        tick();
        bus.w_iss = 0;
        checks++; if ({bus.w_rf_we, bus.w_rf_wa, bus.w_busy[9]} !== {1'b1, 5'd9, 1'b1}) begin
            errors++; $display("FAIL set_wins got we=%b wa=%0d busy9=%b want 1/9/1", bus.w_rf_we, bus.w_rf_wa, bus.w_busy[9]); end
    endtask

    task automatic test_reset_mid();
        bus.w_p_we = 1; bus.w_p_wa = 3; bus.w_p_wd = 32'h33;
        bus.w_iss = 1; bus.w_iss_rd = 10;
        tick();
        bus.w_iss = 0;
        for (int k = 13; k <= 15; k++) begin
            bus.w_l_valid = 1; bus.w_l_wa = 5'(k); bus.w_l_wd = 32'(k);
            tick();
        end
        bus.w_l_valid = 0;
        checks++; if ({bus.w_cnt, bus.w_busy[10]} !== {3'd3, 1'b1}) begin
            errors++; $display("FAIL pre_reset got cnt=%0d busy10=%b want 3/1", bus.w_cnt, bus.w_busy[10]); end
        rst = 1;
        tick();
        rst = 0;
        checks++; if ({bus.w_cnt, bus.w_busy, bus.w_rf_we, bus.w_rf_wa, bus.w_rf_wd} !== {3'd0, 32'd0, 1'b0, 5'd0, 32'd0}) begin
            errors++; $display("FAIL mid_reset got cnt=%0d busy=%h we=%b wa=%0d wd=%h want all 0", bus.w_cnt, bus.w_busy, bus.w_rf_we, bus.w_rf_wa, bus.w_rf_wd); end
        bus.w_p_we = 0;
        tick();
    endtask

`ifdef WB_ANTI_STARVE_EN
    task automatic test_starve();
        bus.w_p_we = 1; bus.w_p_wa = 12; bus.w_p_wd = 32'hC0C0;
        bus.w_l_valid = 1; bus.w_l_wa = 11; bus.w_l_wd = 32'hB0B0;
        tick();
        bus.w_l_valid = 0;
        for (int c = 1; c <= 5; c++) begin
            checks++; if (bus.w_p_stall !== (c == 5)) begin
                errors++; $display("FAIL starve_stall[%0d] got %b want %b", c, bus.w_p_stall, (c == 5)); end
            tick();
            checks++; if ({bus.w_rf_we, bus.w_rf_wa} !== {1'b1, (c == 5) ? 5'd11 : 5'd12}) begin
                errors++; $display("FAIL starve_write[%0d] got we=%b wa=%0d", c, bus.w_rf_we, bus.w_rf_wa); end
        end
        checks++; if (bus.w_p_stall !== 1'b0) begin errors++; $display("FAIL starve_release got %b want 0", bus.w_p_stall); end
        tick();
        checks++; if ({bus.w_rf_we, bus.w_rf_wa, bus.w_rf_wd} !== {1'b1, 5'd12, 32'hC0C0}) begin
            errors++; $display("FAIL starve_held got we=%b wa=%0d wd=%h want 1/12/c0c0", bus.w_rf_we, bus.w_rf_wa, bus.w_rf_wd); end
        bus.w_p_we = 0;
        tick();
    endtask
`endif

    task automatic test_random();
        logic stall_exp;
        for (int n = 0; n < 400; n++) begin
            if (!(bus.w_p_stall === 1'b1)) begin
                bus.w_p_we = ($urandom_range(0, 99) < 55);
                bus.w_p_wa = 5'($urandom_range(0, 31));
                bus.w_p_wd = $urandom;
            end
            bus.w_iss     = ($urandom_range(0, 99) < 30);
            bus.w_iss_rd  = 5'($urandom_range(0, 31));
            bus.w_l_valid = ($urandom_range(0, 99) < 60);
            bus.w_l_wa    = 5'($urandom_range(0, 31));
            bus.w_l_wd    = $urandom;
            rst           = ($urandom_range(0, 99) == 0);
            tick();
            rst = 0;
            stall_exp = 1'b0;
`ifdef WB_ANTI_STARVE_EN
            stall_exp = (m_starve == STARVE);
`endif
            checks++; if (bus.w_rf_we !== m_we) begin errors++; $display("FAIL rnd_we @%0d got %b want %b", n, bus.w_rf_we, m_we); end
            checks++; if ({bus.w_rf_wa, bus.w_rf_wd} !== {m_wa, m_wd}) begin
                errors++; $display("FAIL rnd_wawd @%0d got %0d/%h want %0d/%h", n, bus.w_rf_wa, bus.w_rf_wd, m_wa, m_wd); end
            checks++; if (bus.w_busy !== m_busy) begin errors++; $display("FAIL rnd_busy @%0d got %h want %h", n, bus.w_busy, m_busy); end
            checks++; if (bus.w_cnt !== 3'(m_q.size())) begin errors++; $display("FAIL rnd_cnt @%0d got %0d want %0d", n, bus.w_cnt, m_q.size()); end
            checks++; if (bus.w_l_ready !== (m_q.size() != DEPTH)) begin errors++; $display("FAIL rnd_ready @%0d got %b", n, bus.w_l_ready); end
            checks++; if (bus.w_p_stall !== stall_exp) begin errors++; $display("FAIL rnd_stall @%0d got %b want %b", n, bus.w_p_stall, stall_exp); end
        end
        idle_inputs();
        tick();
    endtask

    initial begin
        test_reset();
        test_pipe_write();
        test_long_latency();
        test_fill_order();
        test_same_cycle_set();
        test_reset_mid();
`ifdef WB_ANTI_STARVE_EN
        test_starve();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
